// File: rtl/ttl_gate_array_filtered.sv
// ttl_gate_array_filtered: BLOCKS independent WIDTH_IN-input gates (AND/NAND/OR/NOR
// selected by Mode). Each gate output is debounced by a persistence counter before it
// reaches Y.
// Optional feature: define TTL_GATE_FILTER_BYPASS_EN to add the Bypass input.
// Ports:
//   Clk        rising-edge clock
//   Clear_bar  asynchronous active-low reset (Y, Changed and all counters to 0)
//   Enable     filter advance enable
//   Mode       00 AND, 01 NAND, 10 OR, 11 NOR (shared by all blocks)
//   A_2D       block i inputs at A_2D[i*WIDTH_IN +: WIDTH_IN]
//   Bypass     (optional) 1 = Y follows raw gate value, Changed held 0
//   Y          filtered gate outputs
//   Changed    one-cycle pulse on the edge where Y[i] updated
module ttl_gate_array_filtered #(
  parameter int unsigned BLOCKS     = 5,
  parameter int unsigned WIDTH_IN   = 3,
  parameter int unsigned FILTER     = 3,
  parameter int unsigned DELAY_RISE = 0,
  parameter int unsigned DELAY_FALL = 0
) (
  input  logic                         Clk,
  input  logic                         Clear_bar,
  input  logic                         Enable,
  input  logic [1:0]                   Mode,
  input  logic [BLOCKS*WIDTH_IN-1:0]   A_2D,
`ifdef TTL_GATE_FILTER_BYPASS_EN
  input  logic                         Bypass,
`endif
  output logic [BLOCKS-1:0]            Y,
  output logic [BLOCKS-1:0]            Changed
);

  localparam int unsigned CNT_W = $clog2(FILTER + 1);

  logic [BLOCKS-1:0]            raw_c;
  logic [BLOCKS-1:0]            y_q, y_d;
  logic [BLOCKS-1:0]            chg_q, chg_d;
  logic [BLOCKS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [BLOCKS-1:0]            y_src;
  logic [BLOCKS-1:0]            chg_src;

  // Raw gate values; reduction operators give x only when no dominating bit is present.
  always_comb begin
    raw_c = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      raw_c[i] = &A_2D[i*WIDTH_IN +: WIDTH_IN];
      case (Mode)
        2'b00:   raw_c[i] =  (&A_2D[i*WIDTH_IN +: WIDTH_IN]);
        2'b01:   raw_c[i] = ~(&A_2D[i*WIDTH_IN +: WIDTH_IN]);
        2'b10:   raw_c[i] =  (|A_2D[i*WIDTH_IN +: WIDTH_IN]);
        2'b11:   raw_c[i] = ~(|A_2D[i*WIDTH_IN +: WIDTH_IN]);
        default: raw_c[i] = &A_2D[i*WIDTH_IN +: WIDTH_IN];
      endcase
    end
  end

  // Per-block persistence filter next state.
  always_comb begin
    y_d   = y_q;
    chg_d = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < BLOCKS; i++) begin
`ifdef TTL_GATE_FILTER_BYPASS_EN
      // Track raw every edge so leaving bypass causes no output step.
      if (Bypass) begin
        y_d[i]   = raw_c[i];
        cnt_d[i] = '0;
      end else
`endif
      if (Enable) begin
        if (raw_c[i] == y_q[i]) begin
          cnt_d[i] = '0;
        end else if (raw_c[i] != y_q[i]) begin
          if (cnt_q[i] == CNT_W'(FILTER - 1)) begin
            y_d[i]   = raw_c[i];
            cnt_d[i] = '0;
            chg_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end else begin
          // Unknown raw value: never commit it, restart persistence.
          cnt_d[i] = '0;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      y_q   <= '0;
      chg_q <= '0;
      cnt_q <= '0;
    end else begin
      y_q   <= y_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef TTL_GATE_FILTER_BYPASS_EN
  assign y_src   = Bypass ? raw_c : y_q;
  assign chg_src = Bypass ? '0 : chg_q;
`else
  assign y_src   = y_q;
  assign chg_src = chg_q;
`endif

  // Output delay stage: distinct rise/fall delays built from two single-delay copies.
  // AND of the copies makes a rise wait for the longer path, OR makes a fall wait.
  if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_nodly
    assign Y       = y_src;
    assign Changed = chg_src;
  end else begin : g_dly
    logic [BLOCKS-1:0] y_r, y_f, c_r, c_f;
    assign #(DELAY_RISE) y_r = y_src;
    assign #(DELAY_FALL) y_f = y_src;
    assign #(DELAY_RISE) c_r = chg_src;
    assign #(DELAY_FALL) c_f = chg_src;
    if (DELAY_RISE >= DELAY_FALL) begin : g_rise_long
      assign Y       = y_r & y_f;
      assign Changed = c_r & c_f;
    end else begin : g_fall_long
      assign Y       = y_r | y_f;
      assign Changed = c_r | c_f;
    end
  end

endmodule

// File: tb/tb_ttl_gate_array_filtered.sv
// Self-checking bench for ttl_gate_array_filtered: main instance (FILTER=3, no delay)
// driven with a queue of expected Y/Changed per edge, plus a FILTER=1 instance with
// rise/fall delays 5/3 for output timing.
module tb_ttl_gate_array_filtered;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [14:0] a;
  logic [4:0]  y;
  logic [4:0]  chg;

  logic        en_dl;
  logic [1:0]  mode_dl;
  logic [14:0] a_dl;
  logic [4:0]  y_dl;
  logic [4:0]  chg_dl;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [4:0] y;
    logic [4:0] c;
  } exp_t;

  exp_t sb[$];

  ttl_gate_array_filtered #(
    .BLOCKS(5), .WIDTH_IN(3), .FILTER(3), .DELAY_RISE(0), .DELAY_FALL(0)
  ) dut (
    .Clk(clk), .Clear_bar(rst_n), .Enable(en), .Mode(mode), .A_2D(a),
`ifdef TTL_GATE_FILTER_BYPASS_EN
    .Bypass(1'b0),
`endif
    .Y(y), .Changed(chg)
  );

  ttl_gate_array_filtered #(
    .BLOCKS(5), .WIDTH_IN(3), .FILTER(1), .DELAY_RISE(5), .DELAY_FALL(3)
  ) dut_dl (
    .Clk(clk), .Clear_bar(rst_n), .Enable(en_dl), .Mode(mode_dl), .A_2D(a_dl),
`ifdef TTL_GATE_FILTER_BYPASS_EN
    .Bypass(1'b0),
`endif
    .Y(y_dl), .Changed(chg_dl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Queue the expectation, advance one edge, then compare against the popped entry.
  task automatic step(input string tag, input logic [4:0] ey, input logic [4:0] ec);
    exp_t e;
    e.tag = tag;
    e.y   = ey;
    e.c   = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty got=%b exp=entry", tag, y);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_y"}, y, e.y);
      check({e.tag, "_chg"}, chg, e.c);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic probe;
    rst_n   = 1'b0;
    en      = 1'b0;
    mode    = 2'b00;
    a       = '1;
    en_dl   = 1'b0;
    mode_dl = 2'b00;
    a_dl    = '0;

    // 1. reset / idle
    #2;
    check("rst_y", y, 5'b00000);
    check("rst_chg", chg, 5'b00000);
    @(posedge clk);
    #1;
    check("rst_hold_y", y, 5'b00000);
    check("rst_dl_y", y_dl, 5'b00000);
    rst_n = 1'b1;
    en    = 1'b1;
    step("idle_e1", 5'b00000, 5'b00000);
    step("idle_e2", 5'b00000, 5'b00000);
    step("idle_e3", 5'b11111, 5'b11111);
    step("idle_e4", 5'b11111, 5'b00000);

    // 2. glitch rejection on block 4
    a[14:12] = 3'b110;
    step("glitch_e1", 5'b11111, 5'b00000);
    step("glitch_e2", 5'b11111, 5'b00000);
    a[14:12] = 3'b111;
    step("glitch_rev", 5'b11111, 5'b00000);
    a[14:12] = 3'b110;
    step("persist_e1", 5'b11111, 5'b00000);
    step("persist_e2", 5'b11111, 5'b00000);
    step("persist_e3", 5'b01111, 5'b10000);
    step("persist_e4", 5'b01111, 5'b00000);

    // 3. mode switch
    a = {3'b000, 3'b111, 3'b010, 3'b101, 3'b111};
    step("and_e1", 5'b01111, 5'b00000);
    step("and_e2", 5'b01111, 5'b00000);
    step("and_e3", 5'b01001, 5'b00110);
    step("and_e4", 5'b01001, 5'b00000);
    mode = 2'b11;
    step("nor_e1", 5'b01001, 5'b00000);
    step("nor_e2", 5'b01001, 5'b00000);
    step("nor_e3", 5'b10000, 5'b11001);
    step("nor_e4", 5'b10000, 5'b00000);

    // 4. enable gating: 2 counting edges, 5 disabled, then the update edge
    mode = 2'b00;
    step("en_cnt1", 5'b10000, 5'b00000);
    step("en_cnt2", 5'b10000, 5'b00000);
    en = 1'b0;
    for (int i = 0; i < 5; i++) step("en_off", 5'b10000, 5'b00000);
    en = 1'b1;
    step("en_upd", 5'b01001, 5'b11001);
    step("en_after", 5'b01001, 5'b00000);

    // 5. async reset between counting edges restarts the count
    mode = 2'b11;
    step("ar_cnt1", 5'b01001, 5'b00000);
    step("ar_cnt2", 5'b01001, 5'b00000);
    rst_n = 1'b0;
    #2;
    check("ar_now_y", y, 5'b00000);
    check("ar_now_chg", chg, 5'b00000);
    #2;
    rst_n = 1'b1;
    step("ar_e1", 5'b00000, 5'b00000);
    step("ar_e2", 5'b00000, 5'b00000);
    step("ar_e3", 5'b10000, 5'b10000);
    step("ar_e4", 5'b10000, 5'b00000);

    // 6a. dominating bit resolves a partly unknown input (NOR: a 1 forces 0)
    a[14:12] = 3'b1x0;
    step("dom_e1", 5'b10000, 5'b00000);
    step("dom_e2", 5'b10000, 5'b00000);
    step("dom_e3", 5'b00000, 5'b10000);
    step("dom_e4", 5'b00000, 5'b00000);

    // 6b. fully unknown inputs hold Y (only meaningful where x is representable)
    probe = 1'bx;
    if ($isunknown(probe)) begin
      a = 'x;
      for (int i = 0; i < 6; i++) step("unk_hold", 5'b00000, 5'b00000);
    end

    // 6c. output rise/fall delay on the FILTER=1 instance
    a_dl[2:0] = 3'b111;
    en_dl     = 1'b1;
    @(posedge clk);
    #4;
    check("dly_rise_early", y_dl, 5'b00000);
    #2;
    check("dly_rise_late", y_dl, 5'b00001);
    check("dly_chg_late", chg_dl, 5'b00001);
    a_dl = '0;
    @(posedge clk);
    #2;
    check("dly_fall_early", y_dl, 5'b00001);
    #2;
    check("dly_fall_late", y_dl, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
